// File: rtl/glyph_pixel_gen.sv
// glyph_pixel_gen: 3-stage pixel pipeline turning region descriptors and glyph ROM rows into RGB plus aligned syncs
module glyph_pixel_gen #(
    parameter logic [23:0] RGB_BG = 24'hf8f9fa,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        bright,
    input  logic [1:0]  mode,
    input  logic [9:0]  x_start,
    input  logic [9:0]  x_end,
    input  logic [9:0]  y_start,
    input  logic [9:0]  y_end,
    input  logic [23:0] rgb_color,
    input  logic [4:0]  gval,
    input  logic [4:0]  gbval,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);
    if (LATENCY != 3) begin : g_latency_fixed
        $error("glyph_pixel_gen: LATENCY is fixed at 3");
    end

    logic [5:0]  dx, dy;
    logic        inreg;
    logic [2:0]  col, row;
    logic [4:0]  idx;
    logic [23:0] pix;

    logic [2:0]  col1, col2;
    logic [1:0]  mode1, mode2;
    logic        inreg1, inreg2, bright1, bright2, hs1, hs2, vs1, vs2;
    logic [23:0] rgb1, rgb2;

    // Region test and glyph coordinates; only the low 6 offset bits matter, so glyphs repeat in oversized regions
    always_comb begin
        dx    = hcount[5:0] - x_start[5:0];
        dy    = vcount[5:0] - y_start[5:0];
        inreg = (hcount >= x_start) && (hcount < x_end) && (vcount >= y_start) && (vcount < y_end);
        col   = (mode == 2'b10) ? dx[5:3] : dx[2:0];
        row   = (mode == 2'b10) ? dy[5:3] : (mode == 2'b01) ? dy[2:0] : 3'd0;
        idx   = (mode == 2'b10) ? gbval : (mode == 2'b01) ? gval : 5'd0;
    end

    // Final colour from stage-2 side-band and the ROM row that arrives alongside it
    always_comb begin
        pix = !bright2 ? 24'h0 :
              (mode2 == 2'b00) ? rgb2 :
              (mode2 != 2'b11 && inreg2 && rom_data[3'd7 - col2]) ? rgb2 : RGB_BG;
    end

    // Three register stages: address/side-band, ROM wait, output; reset flushes everything to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= 8'h0;
            {col1, mode1, inreg1, rgb1, bright1} <= '0;
            {col2, mode2, inreg2, rgb2, bright2} <= '0;
            {hs1, vs1, hs2, vs2} <= 4'hf;
            {vga_r, vga_g, vga_b} <= 24'h0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            rom_addr <= {idx, row};
            col1     <= col;
            mode1    <= mode;
            inreg1   <= inreg;
            rgb1     <= rgb_color;
            bright1  <= bright;
            hs1      <= hsync_in;
            vs1      <= vsync_in;
            col2     <= col1;
            mode2    <= mode1;
            inreg2   <= inreg1;
            rgb2     <= rgb1;
            bright2  <= bright1;
            hs2      <= hs1;
            vs2      <= vs1;
            {vga_r, vga_g, vga_b} <= pix;
            vga_hs      <= hs2;
            vga_vs      <= vs2;
            vga_blank_n <= bright2;
        end
    end
endmodule

// File: tb/tb_glyph_pixel_gen.sv
// tb_glyph_pixel_gen: directed checks of reset, glyph lookup, scaling, region misses, sync alignment and mid-frame reset
module tb_glyph_pixel_gen;
    localparam logic [23:0] BG = 24'hf8f9fa;
    localparam logic [23:0] FG = 24'hff2121;

    logic        clk = 0, rst = 1;
    logic [9:0]  hcount = 0, vcount = 0, x_start = 0, x_end = 0, y_start = 0, y_end = 0;
    logic        hsync_in = 1, vsync_in = 1, bright = 1;
    logic [1:0]  mode = 2'b00;
    logic [23:0] rgb_color = FG;
    logic [4:0]  gval = 0, gbval = 0;
    logic [7:0]  rom_addr, rom_data = 0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n;
    int          n_cmp = 0, n_bad = 0;

    glyph_pixel_gen dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bright(bright), .mode(mode),
        .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
        .rgb_color(rgb_color), .gval(gval), .gbval(gbval),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return (a == 8'h82 || a == 8'h55) ? 8'h10 : 8'h00;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " rgb"}, {vga_r, vga_g, vga_b}, 24'h0);
        check({tag, " hs/vs"}, {vga_hs, vga_vs}, 2'b11);
        check({tag, " blank_n"}, vga_blank_n, 1'b0);
    endtask

    initial begin
        int lo;
        step(2);
        check_idle("reset");
        check("reset rom_addr", rom_addr, 8'h00);
        rst = 0;
        step(1);
        check_idle("post-rst e1");
        step(1);
        check_idle("post-rst e2");
        step(1);
        check("post-rst e3 rgb", {vga_r, vga_g, vga_b}, FG);
        check("post-rst e3 blank_n", vga_blank_n, 1'b1);

        mode = 2'b01; gval = 5'h10;
        x_start = 250; x_end = 258; y_start = 270; y_end = 278;
        hcount = 253; vcount = 272;
        step(1);
        check("8x8 rom_addr", rom_addr, 8'h82);
        step(2);
        check("8x8 col3 on", {vga_r, vga_g, vga_b}, FG);
        hcount = 254;
        step(3);
        check("8x8 col4 off", {vga_r, vga_g, vga_b}, BG);
        hcount = 258;
        step(3);
        check("8x8 hcount==x_end", {vga_r, vga_g, vga_b}, BG);
        hcount = 249;
        step(3);
        check("8x8 left of region", {vga_r, vga_g, vga_b}, BG);
        hcount = 253; vcount = 278;
        step(3);
        check("8x8 vcount==y_end", {vga_r, vga_g, vga_b}, BG);

        mode = 2'b10; gbval = 5'h0A;
        x_start = 345; x_end = 409; y_start = 150; y_end = 214;
        hcount = 345 + 24; vcount = 150 + 40;
        step(1);
        check("64x64 rom_addr", rom_addr, 8'h55);
        for (int i = 24; i < 32; i++) begin
            hcount = 10'(345 + i);
            step(3);
            check($sformatf("64x64 px %0d", i), {vga_r, vga_g, vga_b}, FG);
        end
        hcount = 345 + 32;
        step(3);
        check("64x64 px 32", {vga_r, vga_g, vga_b}, BG);

        hcount = 345 + 24;
        mode = 2'b11;
        step(3);
        check("mode 11", {vga_r, vga_g, vga_b}, BG);
        mode = 2'b00; bright = 0;
        step(3);
        check("dark rgb", {vga_r, vga_g, vga_b}, 24'h0);
        check("dark blank_n", vga_blank_n, 1'b0);

        mode = 2'b10; bright = 1;
        step(3);
        check("pre-midrst", {vga_r, vga_g, vga_b}, FG);
        rst = 1;
        step(1);
        check_idle("midrst");
        rst = 0;
        step(1);
        check_idle("midrst e1");
        step(1);
        check_idle("midrst e2");
        step(1);
        check("midrst e3 rgb", {vga_r, vga_g, vga_b}, FG);

        mode = 2'b00; vcount = 100; lo = 0;
        for (int i = 0; i < 800; i++) begin
            int j;
            hcount = 10'(i);
            hsync_in = !(i >= 16 && i <= 111);
            bright = (i < 640);
            step(1);
            j = i - 2;
            check("hs align", vga_hs, (j < 0) ? 1'b1 : !(j >= 16 && j <= 111));
            check("blank align", vga_blank_n, (j < 0) ? 1'b1 : (j < 640));
            if (!vga_hs) lo++;
        end
        hsync_in = 1;
        step(3);
        check("hs width", lo, 96);

        hcount = 700; bright = 0; lo = 0;
        for (int v = 480; v < 500; v++) begin
            vcount = 10'(v);
            vsync_in = !(v >= 490 && v <= 491);
            step(1);
            check("vs align", vga_vs, !(v - 2 >= 490 && v - 2 <= 491));
            if (!vga_vs) lo++;
        end
        check("vs width", lo, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
